// File: rtl/io_rmw_controller_if.sv
// Request/response and I/O-memory bus of the read-modify-write controller.
// The slave modport is the controller; the master modport is the requester plus memory.
interface io_rmw_controller_if;
  logic       req;
  logic [2:0] op;
  logic [7:0] address;
  logic [2:0] bit_index;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rdata;
  logic [7:0] io_address;
  logic [7:0] io_data_out;
  logic       io_write_enable;
  logic [7:0] io_data_in;

  modport slave (
    input  req, op, address, bit_index, wdata, io_data_in,
    output busy, done, err, rdata, io_address, io_data_out, io_write_enable
  );

  modport master (
    output req, op, address, bit_index, wdata, io_data_in,
    input  busy, done, err, rdata, io_address, io_data_out, io_write_enable
  );
endinterface

// File: rtl/io_rmw_controller.sv
// Read-modify-write controller for a small 9-byte I/O memory with bit operations.
// Define IO_RMW_VERIFY_EN to add a read-back VERIFY state after every write.
module io_rmw_controller (
  input logic                clock,
  input logic                reset_s2_n,
  io_rmw_controller_if.slave bus
);

`ifdef IO_RMW_VERIFY_EN
  typedef enum logic [2:0] {IDLE, READ, WRITE, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE} state_t;
`endif

  localparam logic [2:0] OP_WRITE  = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_TEST   = 3'd5;

  state_t     state;
  state_t     state_next;
  logic [2:0] op_q;
  logic [2:0] bit_q;
  logic [7:0] addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       req_valid;
  logic [7:0] bit_mask;

  assign req_valid = (bus.address <= 8'h08) && (bus.op <= OP_TEST);
  assign bit_mask  = 8'h01 << bit_q;

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (!req_valid)              state_next = DONE;
          else if (bus.op == OP_WRITE) state_next = WRITE;
          else                         state_next = READ;
        end
      end
      READ: begin
        if (op_q == OP_READ || op_q == OP_TEST) state_next = DONE;
        else                                    state_next = WRITE;
      end
`ifdef IO_RMW_VERIFY_EN
      WRITE:   state_next = VERIFY;
      VERIFY:  state_next = DONE;
`else
      WRITE:   state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write data is prepared one state ahead so io_data_out is stable for the whole strobe.
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      op_q      <= 3'd0;
      bit_q     <= 3'd0;
      addr_q    <= 8'h00;
      wr_data_q <= 8'h00;
      rdata_q   <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            op_q   <= bus.op;
            bit_q  <= bus.bit_index;
            addr_q <= bus.address;
            err_q  <= !req_valid;
            if (bus.op == OP_WRITE) wr_data_q <= bus.wdata;
          end
        end
        READ: begin
          case (op_q)
            OP_READ:   rdata_q   <= bus.io_data_in;
            OP_TEST:   rdata_q   <= {7'd0, bus.io_data_in[bit_q]};
            OP_SET:    wr_data_q <= bus.io_data_in | bit_mask;
            OP_CLEAR:  wr_data_q <= bus.io_data_in & ~bit_mask;
            OP_TOGGLE: wr_data_q <= bus.io_data_in ^ bit_mask;
            default:   ;
          endcase
        end
`ifdef IO_RMW_VERIFY_EN
        VERIFY: begin
          if (bus.io_data_in != wr_data_q) err_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);
  assign bus.io_write_enable = (state == WRITE);
  assign bus.io_address      = addr_q;
  assign bus.io_data_out     = wr_data_q;
  assign bus.rdata           = rdata_q;
  assign bus.err             = err_q;

endmodule
